// File: rtl/bank_mshr_buffer.sv
// bank_mshr_buffer: per-bank in-order MSHR queue that presents its oldest miss to the cache bank.
// Optional feature macro MSHR_WRITE_MERGE_EN: write misses merge into the youngest matching unlocked entry.
module bank_mshr_buffer #(
   parameter int MSHR_DEPTH = 4,
   parameter int BLOCK_SIZE = 4,
   parameter int WORD_W     = 32,
   parameter int TAG_W      = 24,
   parameter int INDEX_W    = 4,
   parameter int UUID_W     = 4
) (
   input  logic                            CLK,
   input  logic                            nRST,
   input  logic                            miss_valid,
   output logic                            miss_ready,
   input  logic                            miss_rw,
   input  logic [TAG_W-1:0]                miss_tag,
   input  logic [INDEX_W-1:0]              miss_index,
   input  logic [$clog2(BLOCK_SIZE)-1:0]   miss_offset,
   input  logic [WORD_W-1:0]               miss_store_value,
   input  logic [UUID_W-1:0]               miss_uuid,
   input  logic                            bank_busy,
   input  logic                            bank_uuid_ready,
   output logic                            mshr_valid,
   output logic [UUID_W-1:0]               mshr_uuid,
   output logic [TAG_W-1:0]                mshr_tag,
   output logic [INDEX_W-1:0]              mshr_index,
   output logic [BLOCK_SIZE-1:0]           mshr_write_status,
   output logic [BLOCK_SIZE*WORD_W-1:0]    mshr_write_block,
   output logic                            merge_ack,
   output logic [UUID_W-1:0]               merge_uuid,
   output logic                            mshr_empty,
   output logic [$clog2(MSHR_DEPTH):0]     mshr_count
);
   localparam int PTR_W = $clog2(MSHR_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {H_IDLE, H_PRESENT, H_LOCKED} head_state_t;
   head_state_t state, state_next;

   logic [MSHR_DEPTH-1:0]         ent_valid;
   logic [UUID_W-1:0]             ent_uuid   [MSHR_DEPTH];
   logic [TAG_W-1:0]              ent_tag    [MSHR_DEPTH];
   logic [INDEX_W-1:0]            ent_index  [MSHR_DEPTH];
   logic [BLOCK_SIZE-1:0]         ent_status [MSHR_DEPTH];
   logic [BLOCK_SIZE*WORD_W-1:0]  ent_block  [MSHR_DEPTH];

   logic [PTR_W-1:0]              head_ptr, tail_ptr, merge_idx;
   logic [CNT_W-1:0]              count, count_next;
   logic                          full, merge_ok, accept, alloc, do_merge, pop;
   logic [BLOCK_SIZE-1:0]         new_status;
   logic [BLOCK_SIZE*WORD_W-1:0]  new_block;

   // Handshake: a miss transfers on a CLK rise where miss_valid && miss_ready; miss_ready looks at
   // the presented miss (merge eligibility) but never at miss_valid itself.
   assign full     = (count == CNT_W'(MSHR_DEPTH));
   assign miss_ready = !full || merge_ok;
   assign accept   = miss_valid && miss_ready;
   assign do_merge = accept && merge_ok;
   assign alloc    = accept && !merge_ok;
   assign pop      = (state == H_LOCKED) && bank_uuid_ready;

   always_comb begin
      new_status = '0;
      new_status[miss_offset] = 1'b1;
      new_block = '0;
      new_block[miss_offset*WORD_W +: WORD_W] = miss_store_value;
   end

`ifdef MSHR_WRITE_MERGE_EN
   logic             cand_hit;
   logic [PTR_W-1:0] cand_idx;

   // Walk oldest to youngest so the last match found is the youngest one.
   always_comb begin
      cand_hit = 1'b0;
      cand_idx = '0;
      for (int i = 0; i < MSHR_DEPTH; i++) begin
         if (ent_valid[head_ptr + PTR_W'(i)] &&
             ent_tag[head_ptr + PTR_W'(i)] == miss_tag &&
             ent_index[head_ptr + PTR_W'(i)] == miss_index) begin
            cand_hit = 1'b1;
            cand_idx = head_ptr + PTR_W'(i);
         end
      end
   end

   assign merge_ok  = miss_rw && cand_hit && !(state == H_LOCKED && cand_idx == head_ptr);
   assign merge_idx = cand_idx;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         merge_ack  <= 1'b0;
         merge_uuid <= '0;
      end else begin
         merge_ack  <= do_merge;
         merge_uuid <= do_merge ? miss_uuid : '0;
      end
   end
`else
   assign merge_ok   = 1'b0;
   assign merge_idx  = '0;
   assign merge_ack  = 1'b0;
   assign merge_uuid = '0;
`endif

   always_comb begin
      count_next = count;
      if (alloc && !pop)
         count_next = count + 1'b1;
      else if (!alloc && pop && count != '0)
         count_next = count - 1'b1;
   end

   always_comb begin
      state_next = state;
      case (state)
         H_IDLE:    if (count_next != '0) state_next = H_PRESENT;
         H_PRESENT: if (bank_busy) state_next = H_LOCKED;
         H_LOCKED:  if (pop) state_next = (count_next != '0) ? H_PRESENT : H_IDLE;
         default:   state_next = H_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= H_IDLE;
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         ent_valid <= '0;
         for (int i = 0; i < MSHR_DEPTH; i++) begin
            ent_uuid[i]   <= '0;
            ent_tag[i]    <= '0;
            ent_index[i]  <= '0;
            ent_status[i] <= '0;
            ent_block[i]  <= '0;
         end
      end else begin
         state <= state_next;
         count <= count_next;
         if (pop) begin
            ent_valid[head_ptr] <= 1'b0;
            head_ptr <= head_ptr + 1'b1;
         end
         if (alloc) begin
            ent_valid[tail_ptr]  <= 1'b1;
            ent_uuid[tail_ptr]   <= miss_uuid;
            ent_tag[tail_ptr]    <= miss_tag;
            ent_index[tail_ptr]  <= miss_index;
            ent_status[tail_ptr] <= miss_rw ? new_status : '0;
            ent_block[tail_ptr]  <= miss_rw ? new_block : '0;
            tail_ptr <= tail_ptr + 1'b1;
         end
         if (do_merge) begin
            ent_status[merge_idx] <= ent_status[merge_idx] | new_status;
            ent_block[merge_idx][miss_offset*WORD_W +: WORD_W] <= miss_store_value;
         end
      end
   end

   // Head outputs come straight from storage, so they hold through the pop cycle.
   assign mshr_valid        = (state != H_IDLE);
   assign mshr_uuid         = mshr_valid ? ent_uuid[head_ptr]   : '0;
   assign mshr_tag          = mshr_valid ? ent_tag[head_ptr]    : '0;
   assign mshr_index        = mshr_valid ? ent_index[head_ptr]  : '0;
   assign mshr_write_status = mshr_valid ? ent_status[head_ptr] : '0;
   assign mshr_write_block  = mshr_valid ? ent_block[head_ptr]  : '0;
   assign mshr_empty        = (count == '0);
   assign mshr_count        = count;

endmodule

// File: tb/tb_bank_mshr_buffer.sv
// Directed bench for bank_mshr_buffer; expectations follow the MSHR_WRITE_MERGE_EN setting of the build.
module tb_bank_mshr_buffer;
`ifdef MSHR_WRITE_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          nRST;
   logic          miss_valid, miss_ready, miss_rw;
   logic [23:0]   miss_tag;
   logic [3:0]    miss_index;
   logic [1:0]    miss_offset;
   logic [31:0]   miss_store_value;
   logic [3:0]    miss_uuid;
   logic          bank_busy, bank_uuid_ready;
   logic          mshr_valid;
   logic [3:0]    mshr_uuid;
   logic [23:0]   mshr_tag;
   logic [3:0]    mshr_index;
   logic [3:0]    mshr_write_status;
   logic [127:0]  mshr_write_block;
   logic          merge_ack;
   logic [3:0]    merge_uuid;
   logic          mshr_empty;
   logic [2:0]    mshr_count;

   int n_checks = 0;
   int n_fail   = 0;

   bank_mshr_buffer dut (
      .CLK(CLK), .nRST(nRST),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_rw(miss_rw),
      .miss_tag(miss_tag), .miss_index(miss_index), .miss_offset(miss_offset),
      .miss_store_value(miss_store_value), .miss_uuid(miss_uuid),
      .bank_busy(bank_busy), .bank_uuid_ready(bank_uuid_ready),
      .mshr_valid(mshr_valid), .mshr_uuid(mshr_uuid), .mshr_tag(mshr_tag),
      .mshr_index(mshr_index), .mshr_write_status(mshr_write_status),
      .mshr_write_block(mshr_write_block), .merge_ack(merge_ack),
      .merge_uuid(merge_uuid), .mshr_empty(mshr_empty), .mshr_count(mshr_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_miss(input logic rw, input logic [23:0] tag, input logic [3:0] idx,
                           input logic [1:0] off, input logic [31:0] val, input logic [3:0] uuid);
      miss_valid = 1'b1;
      miss_rw = rw;
      miss_tag = tag;
      miss_index = idx;
      miss_offset = off;
      miss_store_value = val;
      miss_uuid = uuid;
   endtask

   task automatic no_miss();
      miss_valid = 1'b0;
      miss_rw = 1'b0;
      miss_tag = '0;
      miss_index = '0;
      miss_offset = '0;
      miss_store_value = '0;
      miss_uuid = '0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         bank_busy = 1'b1;
         step();
         bank_busy = 1'b0;
         bank_uuid_ready = 1'b1;
         step();
         bank_uuid_ready = 1'b0;
      end
   endtask

   initial begin
      nRST = 1'b0;
      bank_busy = 1'b0;
      bank_uuid_ready = 1'b0;
      no_miss();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_valid", mshr_valid, 1'b0);
      chk("rst_empty", mshr_empty, 1'b1);
      chk("rst_ready", miss_ready, 1'b1);
      chk("rst_count", mshr_count, 3'd0);
      chk("rst_merge_ack", merge_ack, 1'b0);
      chk("rst_uuid", mshr_uuid, 4'd0);
      nRST = 1'b1;
      step();

      // Single read miss, presented one cycle after accept, then serviced.
      set_miss(1'b0, 24'h12, 4'd3, 2'd0, 32'h0, 4'd1);
      #1 chk("rd_ready", miss_ready, 1'b1);
      step();
      no_miss();
      #1;
      chk("rd_valid", mshr_valid, 1'b1);
      chk("rd_uuid", mshr_uuid, 4'd1);
      chk("rd_tag", mshr_tag, 24'h12);
      chk("rd_index", mshr_index, 4'd3);
      chk("rd_status", mshr_write_status, 4'b0000);
      chk("rd_count", mshr_count, 3'd1);
      bank_busy = 1'b1;
      step();
      bank_busy = 1'b0;
      bank_uuid_ready = 1'b1;
      #1;
      chk("rd_hold_valid", mshr_valid, 1'b1);
      chk("rd_hold_uuid", mshr_uuid, 4'd1);
      step();
      bank_uuid_ready = 1'b0;
      #1;
      chk("rd_pop_valid", mshr_valid, 1'b0);
      chk("rd_pop_empty", mshr_empty, 1'b1);
      chk("rd_pop_count", mshr_count, 3'd0);

      // Two writes to one block before lock.
      set_miss(1'b1, 24'h20, 4'd5, 2'd1, 32'hAAAA, 4'd2);
      step();
      set_miss(1'b1, 24'h20, 4'd5, 2'd3, 32'hBBBB, 4'd3);
      #1 chk("mg_ready", miss_ready, 1'b1);
      step();
      no_miss();
      #1;
      chk("mg_count", mshr_count, MERGE ? 3'd1 : 3'd2);
      chk("mg_uuid", mshr_uuid, 4'd2);
      chk("mg_status", mshr_write_status, MERGE ? 4'b1010 : 4'b0010);
      chk("mg_block", mshr_write_block,
          MERGE ? 128'h0000BBBB_00000000_0000AAAA_00000000 : 128'h00000000_00000000_0000AAAA_00000000);
      chk("mg_ack", merge_ack, MERGE);
      chk("mg_ack_uuid", merge_uuid, MERGE ? 4'd3 : 4'd0);

      // Lock the head, then a write to the same block must allocate.
      bank_busy = 1'b1;
      step();
      bank_busy = 1'b0;
      set_miss(1'b1, 24'h20, 4'd5, 2'd0, 32'hCCCC, 4'd4);
      #1 chk("lk_ready", miss_ready, 1'b1);
      step();
      no_miss();
      #1;
      chk("lk_count", mshr_count, MERGE ? 3'd2 : 3'd3);
      chk("lk_no_ack", merge_ack, 1'b0);
      bank_uuid_ready = 1'b1;
      step();
      bank_uuid_ready = 1'b0;
      #1;
      chk("lk_next_uuid", mshr_uuid, MERGE ? 4'd4 : 4'd3);
      chk("lk_next_status", mshr_write_status, MERGE ? 4'b0001 : 4'b1000);
      chk("lk_next_block", mshr_write_block,
          MERGE ? 128'h00000000_00000000_00000000_0000CCCC : 128'h0000BBBB_00000000_00000000_00000000);
      chk("lk_next_count", mshr_count, MERGE ? 3'd1 : 3'd2);
      drain(MERGE ? 1 : 2);
      #1 chk("drain_empty", mshr_empty, 1'b1);

      // Fill with four distinct reads, then stall, then merge while full.
      for (int k = 0; k < 4; k++) begin
         set_miss(1'b0, 24'(32'h40 + k), 4'd1, 2'd0, 32'h0, 4'(5 + k));
         #1 chk("fill_ready", miss_ready, 1'b1);
         step();
      end
      no_miss();
      #1;
      chk("full_count", mshr_count, 3'd4);
      chk("full_ready", miss_ready, 1'b0);
      set_miss(1'b0, 24'h44, 4'd1, 2'd0, 32'h0, 4'd9);
      #1 chk("full_rd_stall", miss_ready, 1'b0);
      step();
      no_miss();
      #1 chk("full_rd_count", mshr_count, 3'd4);
      set_miss(1'b1, 24'h43, 4'd1, 2'd2, 32'hDDDD, 4'd10);
      #1 chk("full_wr_ready", miss_ready, MERGE);
      step();
      no_miss();
      #1;
      chk("full_wr_count", mshr_count, 3'd4);
      chk("full_wr_ack", merge_ack, MERGE);
      chk("full_wr_ack_uuid", merge_uuid, MERGE ? 4'd10 : 4'd0);
      chk("full_head", mshr_uuid, 4'd5);

      // Pop while full does not admit a read in the same cycle.
      bank_busy = 1'b1;
      step();
      bank_busy = 1'b0;
      bank_uuid_ready = 1'b1;
      set_miss(1'b0, 24'h45, 4'd1, 2'd0, 32'h0, 4'd11);
      #1 chk("popfull_ready", miss_ready, 1'b0);
      step();
      bank_uuid_ready = 1'b0;
      no_miss();
      #1;
      chk("popfull_count", mshr_count, 3'd3);
      chk("popfull_head", mshr_uuid, 4'd6);
      drain(1);
      #1;
      chk("pop_count", mshr_count, 3'd2);
      chk("pop_head", mshr_uuid, 4'd7);

      // Pop and accept in the same cycle at count 2.
      bank_busy = 1'b1;
      step();
      bank_busy = 1'b0;
      bank_uuid_ready = 1'b1;
      set_miss(1'b0, 24'h50, 4'd1, 2'd0, 32'h0, 4'd12);
      step();
      bank_uuid_ready = 1'b0;
      no_miss();
      #1;
      chk("pa_count", mshr_count, 3'd2);
      chk("pa_head", mshr_uuid, 4'd8);
      chk("pa_head_status", mshr_write_status, MERGE ? 4'b0100 : 4'b0000);
      chk("pa_head_block", mshr_write_block,
          MERGE ? 128'h00000000_0000DDDD_00000000_00000000 : 128'h0);
      for (int k = 0; k < 4; k++) begin
         bank_busy = 1'b1;
         step();
         bank_busy = 1'b0;
         bank_uuid_ready = 1'b1;
         set_miss(1'b0, 24'(32'h51 + k), 4'd1, 2'd0, 32'h0, 4'(k + 1));
         step();
         bank_uuid_ready = 1'b0;
         no_miss();
         #1;
         chk("wrap_count", mshr_count, 3'd2);
         chk("wrap_head", mshr_uuid, (k == 0) ? 4'd12 : 4'(k));
      end
      chk("wrap_tag", mshr_tag, 24'h53);

      // Write into the presented head in the same cycle bank_busy rises.
      bank_busy = 1'b1;
      set_miss(1'b1, 24'h53, 4'd1, 2'd0, 32'hEEEE, 4'd5);
      #1 chk("hd_ready", miss_ready, 1'b1);
      step();
      bank_busy = 1'b0;
      no_miss();
      #1;
      chk("hd_count", mshr_count, MERGE ? 3'd2 : 3'd3);
      chk("hd_uuid", mshr_uuid, 4'd3);
      chk("hd_status", mshr_write_status, MERGE ? 4'b0001 : 4'b0000);
      chk("hd_block", mshr_write_block, MERGE ? 128'h0000EEEE : 128'h0);
      chk("hd_ack", merge_ack, MERGE);

      // Reset while locked discards everything.
      set_miss(1'b0, 24'h60, 4'd1, 2'd0, 32'h0, 4'd6);
      step();
      no_miss();
      #1 chk("pre_rst_count", mshr_count, MERGE ? 3'd3 : 3'd4);
      nRST = 1'b0;
      #1;
      chk("mid_rst_valid", mshr_valid, 1'b0);
      chk("mid_rst_count", mshr_count, 3'd0);
      chk("mid_rst_empty", mshr_empty, 1'b1);
      chk("mid_rst_ready", miss_ready, 1'b1);
      chk("mid_rst_ack", merge_ack, 1'b0);
      chk("mid_rst_uuid", mshr_uuid, 4'd0);
      chk("mid_rst_status", mshr_write_status, 4'b0000);
      step();
      nRST = 1'b1;
      bank_uuid_ready = 1'b1;
      step();
      bank_uuid_ready = 1'b0;
      #1;
      chk("post_rst_valid", mshr_valid, 1'b0);
      chk("post_rst_count", mshr_count, 3'd0);
      chk("post_rst_empty", mshr_empty, 1'b1);
      set_miss(1'b0, 24'h70, 4'd2, 2'd0, 32'h0, 4'd7);
      step();
      no_miss();
      #1;
      chk("resume_valid", mshr_valid, 1'b1);
      chk("resume_uuid", mshr_uuid, 4'd7);
      chk("resume_count", mshr_count, 3'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bank_mshr_buffer.md
# bank_mshr_buffer

Per-bank miss status holding register queue that sits directly upstream of the cache bank. It accepts primary misses from the request scheduler and stores them in order. It presents the oldest entry to the bank as the `mshr_*` entry and retires that entry when the bank signals completion. Write misses that target a block already queued are merged into that entry instead of taking a new slot.

## Interface
Parameters:
- MSHR_DEPTH, 4, number of entries; power of two, at least 2
- BLOCK_SIZE, 4, words per block; power of two
- WORD_W, 32, word width
- TAG_W, 24, tag width
- INDEX_W, 4, full set-index field width (bank bits included)
- UUID_W, 4, request uuid width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- miss_valid  in  1  scheduler presents a miss this cycle
- miss_ready  out  1  miss accepted this cycle (combinational)
- miss_rw  in  1  1 = write, 0 = read
- miss_tag  in  TAG_W  block tag
- miss_index  in  INDEX_W  block index
- miss_offset  in  log2(BLOCK_SIZE)  word offset in the block
- miss_store_value  in  WORD_W  write data
- miss_uuid  in  UUID_W  request id
- bank_busy  in  1  cache bank is servicing the presented entry
- bank_uuid_ready  in  1  one-cycle pulse: the bank finished the presented entry
- mshr_valid  out  1  head entry valid
- mshr_uuid  out  UUID_W  head uuid
- mshr_tag  out  TAG_W  head tag
- mshr_index  out  INDEX_W  head index
- mshr_write_status  out  BLOCK_SIZE  per-word write mask of head
- mshr_write_block  out  BLOCK_SIZE*WORD_W  write data of head; word w sits at bits [w*WORD_W +: WORD_W]
- merge_ack  out  1  registered pulse: a write was merged
- merge_uuid  out  UUID_W  uuid of the merged write
- mshr_empty  out  1  no valid entries; gates bank halt/flush
- mshr_count  out  log2(MSHR_DEPTH)+1  occupancy

## Operation
- Storage is a circular buffer with head_ptr, tail_ptr and count.
  - Each entry holds valid, uuid, tag, index, write_status[BLOCK_SIZE] and write_block[BLOCK_SIZE].
- Allocation happens when miss_valid && miss_ready and the miss does not merge. The new entry is written at tail_ptr and tail_ptr increments.
  - Read miss: write_status = 0.
  - Write miss: write_status = one-hot(miss_offset) and write_block[miss_offset] = miss_store_value.
- Merge candidate: the youngest valid entry with matching {tag, index}.
  - A write merges only if that candidate is unlocked. A write that merges sets write_status[offset] and overwrites write_block[offset]. A later merged write to the same offset overwrites the earlier one.
  - merge_ack and merge_uuid = miss_uuid are driven the following cycle.
  - A read miss, or a write whose youngest match is locked, always allocates.
- miss_ready = (count < MSHR_DEPTH) || merge-eligible write.
- Head FSM has three states:
  - H_IDLE: count == 0. Moves to H_PRESENT when count becomes nonzero.
  - H_PRESENT: mshr_valid = 1. Moves to H_LOCKED when bank_busy is sampled high.
  - H_LOCKED: the head entry is excluded from merging. On bank_uuid_ready it pops: head entry valid is cleared, head_ptr increments, and the FSM moves to H_PRESENT if entries remain, otherwise H_IDLE.
- Outputs mshr_* reflect the entry at head_ptr. They are zero when mshr_valid = 0.
- bank_uuid_ready outside H_LOCKED is ignored.

## Timing
- Reset values:
  - All outputs 0, except mshr_empty = 1 and miss_ready = 1.
  - Pointers, count and entries are cleared; the FSM is in H_IDLE.
- A reset mid-service discards all entries.
- Enqueue to presentation: an empty buffer shows the new entry with mshr_valid = 1 on the cycle after the accept edge. There is no combinational bypass.
- Head outputs are held stable through the bank_uuid_ready cycle. The next entry appears on the following cycle, so the bank sees it when it returns to its start state.
- Accept and pop in the same cycle: count stays the same; pointers move independently.
  - When full, accept is allowed only for a merge. A pop does not free a slot for the same cycle's accept.
- Write merge into the head while in H_PRESENT, in the same cycle bank_busy rises: the merge is accepted because lock takes effect next edge, and the merged data is visible before the bank latches.
- Pointers wrap modulo MSHR_DEPTH. count saturates at MSHR_DEPTH and never underflows.

## Configuration
- MSHR_WRITE_MERGE_EN
  - Defined: write merging as described above.
  - Undefined: every accepted miss allocates, miss_ready = (count < MSHR_DEPTH), merge_ack is tied 0, and no tag compare logic is built.

## Test plan
- Read miss, tag 0x12 index 3, uuid 1, into an empty buffer → next cycle mshr_valid = 1, mshr_uuid = 1, write_status = 0000. Assert bank_busy, then pulse bank_uuid_ready → next cycle mshr_valid = 0, mshr_empty = 1.
- Write offset 1, value 0xAAAA, uuid 2, then a write to the same block at offset 3, value 0xBBBB, uuid 3, before lock → one entry with write_status = 1010 and both words set; merge_ack with uuid 3; count = 1.
- Lock the head with bank_busy, then write the same block → new entry allocated, count = 2, no merge_ack.
- Fill 4 distinct-block reads → miss_ready = 0. Send a 5th read → stalled. Send a write to the 4th entry's block → merged, miss_ready = 1.
- Pop while accepting with count = 2 → count stays 2, the next head appears one cycle after the pop; repeat past the wrap to check pointer wrap.
- Assert nRST low while locked with 3 entries → all outputs at reset values immediately; a bank_uuid_ready after release is ignored.
